// File: rtl/uart_rx_edge_filter.sv
// Multi-channel UART rx line conditioner.
// Synchronises, debounces and reports filtered edges per channel.
module uart_rx_edge_filter #(
    parameter int   N_CH        = 1,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              en,
    input  logic [N_CH-1:0]   rx,
    input  logic [2*N_CH-1:0] mode,
    input  logic [N_CH-1:0]   sticky_clr,
    output logic [N_CH-1:0]   rx_filt,
    output logic [N_CH-1:0]   rx_negedge_det,
    output logic [N_CH-1:0]   rx_posedge_det,
    output logic [N_CH-1:0]   edge_det,
    output logic [N_CH-1:0]   edge_sticky
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    genvar i;
    generate
        for (i = 0; i < N_CH; i++) begin : g_ch
            logic          s;
            logic [CW-1:0] cnt;
            logic          filt;
            logic          flip;
            logic          edge_hit;
            logic          fall_q;
            logic          rise_q;
            logic          edge_q;
            logic          sticky_q;

            if (SYNC_STAGES > 0) begin : g_sync
                logic [SYNC_STAGES-1:0] sync_q;

                always_ff @(posedge clk or negedge arst_n) begin
                    if (!arst_n) begin
                        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
                    end else begin
                        sync_q[0] <= rx[i];
                        for (int k = 1; k < SYNC_STAGES; k++) begin
                            sync_q[k] <= sync_q[k-1];
                        end
                    end
                end

                assign s = sync_q[SYNC_STAGES-1];
            end else begin : g_bypass
                assign s = rx[i];
            end

            // flip is the single point where the filtered level changes
            assign flip     = en && (s != filt) && (cnt == CNT_MAX);
            assign edge_hit = flip && (s ? mode[2*i+1] : mode[2*i]);

            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    cnt      <= '0;
                    filt     <= RESET_LEVEL;
                    fall_q   <= 1'b0;
                    rise_q   <= 1'b0;
                    edge_q   <= 1'b0;
                    sticky_q <= 1'b0;
                end else begin
                    fall_q <= flip && !s;
                    rise_q <= flip && s;
                    edge_q <= edge_hit;
                    if (edge_hit) begin
                        sticky_q <= 1'b1;
                    end else if (sticky_clr[i]) begin
                        sticky_q <= 1'b0;
                    end
                    if (!en || (s == filt)) begin
                        cnt <= '0;
                    end else if (flip) begin
                        filt <= s;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end

            assign rx_filt[i]        = filt;
            assign rx_negedge_det[i] = fall_q;
            assign rx_posedge_det[i] = rise_q;
            assign edge_det[i]       = edge_q;
            assign edge_sticky[i]    = sticky_q;
        end
    endgenerate

endmodule
